// File: rtl/trail_write_arbiter.sv
// Frame-buffer SRAM write-port arbiter: the clear engine has fixed priority, blue and red
// alternate round-robin, and each write is a fixed-length strobe followed by one recovery cycle.
module trail_write_arbiter #(
    parameter int unsigned ADDR_W       = 20,
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned WRITE_CYCLES = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              allow,

    input  logic              clr_valid,
    input  logic [ADDR_W-1:0] clr_addr,
    input  logic [DATA_W-1:0] clr_data,
    output logic              clr_ready,

    input  logic              blu_valid,
    input  logic [ADDR_W-1:0] blu_addr,
    input  logic [DATA_W-1:0] blu_data,
    output logic              blu_ready,

    input  logic              red_valid,
    input  logic [ADDR_W-1:0] red_addr,
    input  logic [DATA_W-1:0] red_data,
    output logic              red_ready,

    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_data,
    output logic              sram_we,
    output logic              busy,
    output logic [1:0]        last_grant
);

    localparam int unsigned     CNT_W    = 4;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WRITE_CYCLES - 1);

    localparam logic [1:0] GNT_NONE = 2'd0;
    localparam logic [1:0] GNT_CLR  = 2'd1;
    localparam logic [1:0] GNT_BLU  = 2'd2;
    localparam logic [1:0] GNT_RED  = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WRITE   = 2'd1,
        RECOVER = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic                rr_red_last, rr_red_last_nxt;
    logic [ADDR_W-1:0]   addr_nxt;
    logic [DATA_W-1:0]   data_nxt;
    logic                we_nxt;
    logic [1:0]          last_grant_nxt;
    logic [1:0]          sel;

    // Winner for this cycle; readies are suppressed while Reset is held
    always_comb begin
        sel = GNT_NONE;
        if (state == IDLE && allow && !Reset) begin
            if (clr_valid)
                sel = GNT_CLR;
            else if (blu_valid && red_valid)
                sel = rr_red_last ? GNT_BLU : GNT_RED;
            else if (blu_valid)
                sel = GNT_BLU;
            else if (red_valid)
                sel = GNT_RED;
        end
    end

    assign clr_ready = (sel == GNT_CLR);
    assign blu_ready = (sel == GNT_BLU);
    assign red_ready = (sel == GNT_RED);
    assign busy      = (state != IDLE);

    // Next-state and registered-output logic
    always_comb begin
        state_nxt       = state;
        cnt_nxt         = cnt;
        rr_red_last_nxt = rr_red_last;
        addr_nxt        = sram_addr;
        data_nxt        = sram_data;
        we_nxt          = sram_we;
        last_grant_nxt  = last_grant;

        unique case (state)
            IDLE: begin
                if (sel != GNT_NONE) begin
                    state_nxt      = WRITE;
                    we_nxt         = 1'b1;
                    cnt_nxt        = CNT_LOAD;
                    last_grant_nxt = sel;
                    case (sel)
                        GNT_CLR: begin
                            addr_nxt = clr_addr;
                            data_nxt = clr_data;
                        end
                        GNT_BLU: begin
                            addr_nxt        = blu_addr;
                            data_nxt        = blu_data;
                            rr_red_last_nxt = 1'b0;
                        end
                        default: begin
                            addr_nxt        = red_addr;
                            data_nxt        = red_data;
                            rr_red_last_nxt = 1'b1;
                        end
                    endcase
                end
            end
            WRITE: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - CNT_W'(1);
                end else begin
                    we_nxt    = 1'b0;
                    state_nxt = RECOVER;
                end
            end
            RECOVER: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                we_nxt    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state       <= IDLE;
            cnt         <= '0;
            rr_red_last <= 1'b1;
            sram_addr   <= '0;
            sram_data   <= '0;
            sram_we     <= 1'b0;
            last_grant  <= GNT_NONE;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            rr_red_last <= rr_red_last_nxt;
            sram_addr   <= addr_nxt;
            sram_data   <= data_nxt;
            sram_we     <= we_nxt;
            last_grant  <= last_grant_nxt;
        end
    end

endmodule

// File: doc/trail_write_arbiter.md
# trail_write_arbiter

Shares the single frame-buffer SRAM write port between three requesters: the screen-clear engine, the blue trail writer and the red trail writer. Each requester uses a valid/ready handshake. The arbiter gives the clear engine fixed priority and alternates blue and red round-robin. It then drives a fixed-length SRAM write cycle with a mandatory recovery cycle. It sits between the trail/clear logic and the SRAM pin driver.

## Interface
- ADDR_W, 20, SRAM word address width
- DATA_W, 16, SRAM data width
- WRITE_CYCLES, 2, cycles sram_we is held high per write; legal 1..15

- Clk  in  1  50 MHz system clock; one clock domain
- Reset  in  1  asynchronous, active-high reset
- allow  in  1  write window enable; new grants only while high
- clr_valid  in  1  clear engine request
- clr_addr  in  ADDR_W  clear write address
- clr_data  in  DATA_W  clear write data
- clr_ready  out  1  clear request accepted this cycle
- blu_valid / blu_addr / blu_data / blu_ready  same as clr_*, blue trail writer
- red_valid / red_addr / red_data / red_ready  same as clr_*, red trail writer
- sram_addr  out  ADDR_W  registered write address
- sram_data  out  DATA_W  registered write data
- sram_we  out  1  registered active-high write strobe
- busy  out  1  high whenever state is not IDLE
- last_grant  out  2  last accepted requester: 0 none, 1 clear, 2 blue, 3 red

## Operation
- **FSM states:** IDLE, WRITE, RECOVER.
- **IDLE:**
  - If allow=1 and any valid=1, select a winner, latch its addr/data into sram_addr/sram_data, set sram_we=1, load the cycle counter with WRITE_CYCLES-1, and go to WRITE.
  - Otherwise stay in IDLE.
- **WRITE:**
  - sram_we=1; addr and data held stable.
  - While the counter is nonzero, decrement it.
  - When the counter is zero, clear sram_we and go to RECOVER.
- **RECOVER:**
  - One cycle with sram_we=0 and addr/data still held, then go to IDLE.
- **Selection:**
  - clr_valid wins unconditionally.
  - Otherwise, if exactly one of blu/red is valid, that one wins.
  - If both are valid, the one not granted most recently wins.
- **Round-robin pointer:**
  - 1 bit, rr_red_last; reset value 1, so blue wins the first tie.
  - Updated only on blue or red grants; clear grants leave it unchanged.
- **Ready:**
  - *_ready is combinational: high only in IDLE, with allow=1, for the selected requester.
  - At most one ready is high per cycle.
  - A transfer occurs when valid && ready in the same cycle.
  - Requesters must hold valid, addr and data stable until ready.
  - valid may drop before ready (request withdrawn) with no effect.
- **allow:** deasserting allow mid-write does not abort the write; it only blocks the next grant.
- **Starvation:** continuous clr_valid starves blue/red by design; the clear engine only runs outside Game_State 3'b10.
- **last_grant:** updated on each acceptance; it is not a pending indication.

## Timing
- **Reset values:** sram_we=0, sram_addr=0, sram_data=0, busy=0, last_grant=0, all ready=0, state=IDLE, counter=0, rr_red_last=1.
- **Reset mid-write:** asserting Reset during WRITE drops sram_we asynchronously; the write is lost. No requester sees a second ready for that request.
- **Per-write timeline** (acceptance in cycle N):
  - sram_we high in cycles N+1 .. N+WRITE_CYCLES.
  - RECOVER in cycle N+WRITE_CYCLES+1.
  - Next acceptance possible in cycle N+WRITE_CYCLES+2.
- **Throughput:** one write per WRITE_CYCLES+2 cycles (4 cycles at the default).
- **sram_addr/sram_data:** change only on the clock edge that ends an accepting IDLE cycle. They never change while sram_we=1 or during RECOVER.
- **busy:** high from N+1 through N+WRITE_CYCLES+1.
- **Simultaneous requests:** all three valid in the same cycle → clear granted; blue and red stay pending; their round-robin order is unaffected.

## Test plan
- **Reset:** apply Reset, release it, all valids low → sram_we=0, sram_addr=0, busy=0, last_grant=0, every ready=0 for 20 cycles.
- **Single blue write** (WRITE_CYCLES=2): blu_valid with addr 20'h00A28, data 16'h0F0F, allow=1, accepted in cycle N → blu_ready=1 only in N; sram_we=1 in N+1..N+2 with addr 20'h00A28 and data 16'h0F0F; sram_we=0 in N+3; last_grant=2.
- **Blue/red contention:** blu_valid and red_valid held high for 4 grants → grant order blue, red, blue, red; acceptances 4 cycles apart.
- **Clear priority:** clr_valid, blu_valid and red_valid all high → clear granted first. Then drop clr_valid → blue is granted next (pointer unchanged by the clear grant).
- **allow gating:** allow=0 with blu_valid=1 for 10 cycles → no ready, sram_we=0. Raise allow → blu_ready in that same cycle. Drop allow during WRITE → the write completes its full WRITE_CYCLES.
- **Reset mid-write:** assert Reset in the first WRITE cycle → sram_we=0 with no clock edge; state IDLE; rr_red_last=1. A held blu_valid is re-granted after release.
